// File: rtl/xbar_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xbar_pkg
// Description : Shared crossbar types, AXI burst encodings and index helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package xbar_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } ar_arb_state_e;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    // Master-index width; a single master still needs one bit of index.
    function automatic int midx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/xbar_ar_arbiter_rr_select.sv
`default_nettype none
// ============================================================================
// Module      : rr_select
// Description : Combinational priority search over a request vector, starting
//               at a given pointer and wrapping modulo NUM_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_select #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_start,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_idx
);

    localparam logic [IDX_W-1:0] c_LAST = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W-1:0] c_ONE  = IDX_W'(1);

    logic [IDX_W-1:0] w_cand;

    // Walk every position once; the explicit wrap keeps non-power-of-2 counts in range.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_cand  = i_start;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!o_valid && i_req[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
            end
            w_cand = (w_cand == c_LAST) ? '0 : w_cand + c_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/xbar_ar_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : xbar_ar_arbiter
// Description : Per-slave AR-channel arbiter. Round-robin grant held until the
//               AR handshake, ARID widened with the master index, one FIFO
//               push per accepted AR. Define XBAR_AR_ARB_FIXED_PRIO_EN for
//               fixed lowest-index-wins priority instead of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module xbar_ar_arbiter
    import xbar_pkg::*;
#(
    parameter  int NUM_MASTERS = 2,
    parameter  int ID_WIDTH    = 4,
    parameter  int ADDR_WIDTH  = 32,
    parameter  int LEN_WIDTH   = 4,
    parameter  int SIZE_WIDTH  = 3,
    localparam int MIDX_W      = midx_width(NUM_MASTERS)
) (
    input  logic                              ACLK,
    input  logic                              ARESETn,

    input  logic [NUM_MASTERS-1:0]            m_ARVALID,
    output logic [NUM_MASTERS-1:0]            m_ARREADY,
    input  logic [NUM_MASTERS*ID_WIDTH-1:0]   m_ARID,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_ARADDR,
    input  logic [NUM_MASTERS*LEN_WIDTH-1:0]  m_ARLEN,
    input  logic [NUM_MASTERS*SIZE_WIDTH-1:0] m_ARSIZE,
    input  logic [NUM_MASTERS*2-1:0]          m_ARBURST,

    output logic                              s_ARVALID,
    input  logic                              s_ARREADY,
    output logic [MIDX_W+ID_WIDTH-1:0]        s_ARID,
    output logic [ADDR_WIDTH-1:0]             s_ARADDR,
    output logic [LEN_WIDTH-1:0]              s_ARLEN,
    output logic [SIZE_WIDTH-1:0]             s_ARSIZE,
    output logic [1:0]                        s_ARBURST,

    output logic                              fifo_push,
    input  logic                              fifo_full,
    output logic [MIDX_W-1:0]                 grant_idx
);

    ar_arb_state_e     r_state;
    logic [MIDX_W-1:0] r_grant_idx;

    logic              w_in_grant;
    logic              w_hs;
    logic              w_sel_valid;
    logic [MIDX_W-1:0] w_sel_idx;
    logic [MIDX_W-1:0] w_start;

    logic [ID_WIDTH-1:0]   w_id    [NUM_MASTERS];
    logic [ADDR_WIDTH-1:0] w_addr  [NUM_MASTERS];
    logic [LEN_WIDTH-1:0]  w_len   [NUM_MASTERS];
    logic [SIZE_WIDTH-1:0] w_size  [NUM_MASTERS];
    logic [1:0]            w_burst [NUM_MASTERS];

    generate
        for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
            assign w_id[i]    = m_ARID[i*ID_WIDTH +: ID_WIDTH];
            assign w_addr[i]  = m_ARADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_len[i]   = m_ARLEN[i*LEN_WIDTH +: LEN_WIDTH];
            assign w_size[i]  = m_ARSIZE[i*SIZE_WIDTH +: SIZE_WIDTH];
            assign w_burst[i] = m_ARBURST[i*2 +: 2];
        end
    endgenerate

    rr_select #(
        .NUM_REQ (NUM_MASTERS),
        .IDX_W   (MIDX_W)
    ) u_rr_select (
        .i_req   (m_ARVALID),
        .i_start (w_start),
        .o_valid (w_sel_valid),
        .o_idx   (w_sel_idx)
    );

`ifdef XBAR_AR_ARB_FIXED_PRIO_EN
    assign w_start = '0;
`else
    localparam logic [MIDX_W-1:0] c_LAST_IDX = MIDX_W'(NUM_MASTERS - 1);

    logic [MIDX_W-1:0] r_rr_ptr;

    // The next search starts just past the master that was last served.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_rr_ptr <= '0;
        end else if (w_in_grant && w_hs) begin
            r_rr_ptr <= (r_grant_idx == c_LAST_IDX) ? '0 : r_grant_idx + MIDX_W'(1);
        end
    end

    assign w_start = r_rr_ptr;
`endif

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_state     <= IDLE;
            r_grant_idx <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_sel_valid && !fifo_full) begin
                        r_grant_idx <= w_sel_idx;
                        r_state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_hs) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_in_grant = (r_state == GRANT);
    assign w_hs       = s_ARVALID && s_ARREADY;

    // Slave side only ever sees the registered grant, so IDLE has no m->s valid path.
    assign s_ARVALID = w_in_grant && m_ARVALID[r_grant_idx];
    assign s_ARID    = w_in_grant ? {r_grant_idx, w_id[r_grant_idx]} : '0;
    assign s_ARADDR  = w_in_grant ? w_addr[r_grant_idx]  : '0;
    assign s_ARLEN   = w_in_grant ? w_len[r_grant_idx]   : '0;
    assign s_ARSIZE  = w_in_grant ? w_size[r_grant_idx]  : '0;
    assign s_ARBURST = w_in_grant ? w_burst[r_grant_idx] : '0;

    generate
        for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_ready
            assign m_ARREADY[i] = w_in_grant && (r_grant_idx == MIDX_W'(i)) && s_ARREADY;
        end
    endgenerate

    assign fifo_push = w_in_grant && w_hs;
    assign grant_idx = r_grant_idx;

endmodule
`default_nettype wire

// File: tb/tb_xbar_ar_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_xbar_ar_arbiter
// Description : Scoreboard bench for xbar_ar_arbiter with 2- and 3-master DUTs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xbar_ar_arbiter;

    typedef struct {
        int          idx;
        logic [5:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } exp_t;

    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;
    always #5 ACLK = ~ACLK;

    logic [3:0]  id_tab    [3] = '{4'h3, 4'hA, 4'h5};
    logic [31:0] addr_tab  [3] = '{32'h0000_1000, 32'h0000_2000, 32'h0000_3000};
    logic [3:0]  len_tab   [3] = '{4'd1, 4'd3, 4'd7};
    logic [2:0]  size_tab  [3] = '{3'd2, 3'd3, 3'd1};
    logic [1:0]  burst_tab [3] = '{xbar_pkg::BURST_INCR, xbar_pkg::BURST_WRAP, xbar_pkg::BURST_FIXED};

    logic [1:0]  m2_valid, m2_ready;
    logic [7:0]  m2_id;
    logic [63:0] m2_addr;
    logic [7:0]  m2_len;
    logic [5:0]  m2_size;
    logic [3:0]  m2_burst;
    logic        s2_valid, s2_ready, push2, full2;
    logic [4:0]  s2_id;
    logic [31:0] s2_addr;
    logic [3:0]  s2_len;
    logic [2:0]  s2_size;
    logic [1:0]  s2_burst;
    logic [0:0]  gidx2;

    logic [2:0]  m3_valid, m3_ready;
    logic [11:0] m3_id;
    logic [95:0] m3_addr;
    logic [11:0] m3_len;
    logic [8:0]  m3_size;
    logic [5:0]  m3_burst;
    logic        s3_valid, s3_ready, push3, full3;
    logic [5:0]  s3_id;
    logic [31:0] s3_addr;
    logic [3:0]  s3_len;
    logic [2:0]  s3_size;
    logic [1:0]  s3_burst;
    logic [1:0]  gidx3;

    xbar_ar_arbiter #(.NUM_MASTERS(2)) dut2 (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .m_ARVALID(m2_valid), .m_ARREADY(m2_ready), .m_ARID(m2_id), .m_ARADDR(m2_addr),
        .m_ARLEN(m2_len), .m_ARSIZE(m2_size), .m_ARBURST(m2_burst),
        .s_ARVALID(s2_valid), .s_ARREADY(s2_ready), .s_ARID(s2_id), .s_ARADDR(s2_addr),
        .s_ARLEN(s2_len), .s_ARSIZE(s2_size), .s_ARBURST(s2_burst),
        .fifo_push(push2), .fifo_full(full2), .grant_idx(gidx2)
    );

    xbar_ar_arbiter #(.NUM_MASTERS(3)) dut3 (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .m_ARVALID(m3_valid), .m_ARREADY(m3_ready), .m_ARID(m3_id), .m_ARADDR(m3_addr),
        .m_ARLEN(m3_len), .m_ARSIZE(m3_size), .m_ARBURST(m3_burst),
        .s_ARVALID(s3_valid), .s_ARREADY(s3_ready), .s_ARID(s3_id), .s_ARADDR(s3_addr),
        .s_ARLEN(s3_len), .s_ARSIZE(s3_size), .s_ARBURST(s3_burst),
        .fifo_push(push3), .fifo_full(full3), .grant_idx(gidx3)
    );

    int   n_vec = 0;
    int   n_err = 0;
    exp_t q2[$];
    exp_t q3[$];
    exp_t e2, e3;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int i);
        exp_t e;
        e.idx   = i;
        e.id    = {2'(i), id_tab[i]};
        e.addr  = addr_tab[i];
        e.len   = len_tab[i];
        e.size  = size_tab[i];
        e.burst = burst_tab[i];
        return e;
    endfunction

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    // Scoreboards: each FIFO push is matched against the next expected AR record.
    always @(negedge ACLK) begin
        if (ARESETn && push2) begin
            if (q2.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL d2_unexpected_push: got push, expected none (grant %0d)", gidx2);
            end else begin
                e2 = q2.pop_front();
                chk("d2_grant_idx", gidx2, e2.idx);
                chk("d2_s_arid", s2_id, e2.id);
                chk("d2_s_araddr", s2_addr, e2.addr);
                chk("d2_len_size_burst", {s2_len, s2_size, s2_burst}, {e2.len, e2.size, e2.burst});
                chk("d2_m_arready", m2_ready, 64'(1) << e2.idx);
            end
        end
    end

    always @(negedge ACLK) begin
        if (ARESETn && push3) begin
            if (q3.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL d3_unexpected_push: got push, expected none (grant %0d)", gidx3);
            end else begin
                e3 = q3.pop_front();
                chk("d3_grant_idx", gidx3, e3.idx);
                chk("d3_s_arid", s3_id, e3.id);
                chk("d3_s_araddr", s3_addr, e3.addr);
                chk("d3_len_size_burst", {s3_len, s3_size, s3_burst}, {e3.len, e3.size, e3.burst});
                chk("d3_m_arready", m3_ready, 64'(1) << e3.idx);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        m2_valid = '0; s2_ready = 1'b0; full2 = 1'b0;
        m3_valid = '0; s3_ready = 1'b0; full3 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m2_id[i*4 +: 4]     = id_tab[i];
            m2_addr[i*32 +: 32] = addr_tab[i];
            m2_len[i*4 +: 4]    = len_tab[i];
            m2_size[i*3 +: 3]   = size_tab[i];
            m2_burst[i*2 +: 2]  = burst_tab[i];
        end
        for (int i = 0; i < 3; i++) begin
            m3_id[i*4 +: 4]     = id_tab[i];
            m3_addr[i*32 +: 32] = addr_tab[i];
            m3_len[i*4 +: 4]    = len_tab[i];
            m3_size[i*3 +: 3]   = size_tab[i];
            m3_burst[i*2 +: 2]  = burst_tab[i];
        end

        // Reset state
        repeat (2) step();
        @(negedge ACLK);
        chk("rst_s_arvalid", s2_valid, 0);
        chk("rst_m_arready", m2_ready, 0);
        chk("rst_fifo_push", push2, 0);
        chk("rst_grant_idx", gidx2, 0);
        chk("rst_s_ar_data", {s2_id, s2_addr, s2_len, s2_size, s2_burst}, 0);
        step();
        ARESETn = 1'b1;

        // Single master 0, slave always ready
        m2_valid = 2'b01; s2_ready = 1'b1;
        q2.push_back(mk(0));
        @(negedge ACLK);
        chk("single_idle_no_valid", s2_valid, 0);
        step();
        @(negedge ACLK);
        chk("single_valid_c1", s2_valid, 1);
        chk("single_ready_c1", m2_ready, 2'b01);
        chk("single_arid", s2_id, 5'h03);
        step();
        m2_valid = 2'b00;
        @(negedge ACLK);
        chk("single_back_idle", s2_valid, 0);
        chk("single_push_once", push2, 0);

        // Both masters continuous; pointer sits at 1 after the single grant
        m2_valid = 2'b11;
`ifdef XBAR_AR_ARB_FIXED_PRIO_EN
        for (int k = 0; k < 4; k++) q2.push_back(mk(0));
`else
        for (int k = 0; k < 4; k++) q2.push_back(mk((k % 2 == 0) ? 1 : 0));
`endif
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            @(negedge ACLK);
            if (push2) cnt++;
        end
        m2_valid = 2'b00;
        chk("alt_push_count_8cyc", cnt, 4);

        // Grant to master 1 held under back-pressure, master 0 joins mid-wait
        m2_valid = 2'b10; s2_ready = 1'b0;
        q2.push_back(mk(1));
        step();
        for (int k = 0; k < 5; k++) begin
            @(negedge ACLK);
            chk("hold_grant_idx", gidx2, 1);
            chk("hold_valid", s2_valid, 1);
            chk("hold_no_push", push2, 0);
            chk("hold_fields", {s2_id, s2_addr}, {5'h1A, 32'h0000_2000});
            chk("hold_no_ready", m2_ready, 0);
            if (k == 1) m2_valid = 2'b11;
            step();
        end
        s2_ready = 1'b1;
        @(negedge ACLK);
        chk("hold_release_push", push2, 1);
        step();
        m2_valid = 2'b00;
        @(negedge ACLK);
        chk("hold_back_idle", s2_valid, 0);

        // FIFO full blocks arbitration
        full2 = 1'b1; m2_valid = 2'b01;
        for (int k = 0; k < 3; k++) begin
            step();
            @(negedge ACLK);
            chk("full_no_valid", s2_valid, 0);
        end
        step();
        full2 = 1'b0;
        q2.push_back(mk(0));
        @(negedge ACLK);
        chk("full_drop_cN", s2_valid, 0);
        step();
        @(negedge ACLK);
        chk("full_drop_cN1", s2_valid, 1);
        step();
        m2_valid = 2'b00;

        // Reset while granted to master 1
        m2_valid = 2'b10; s2_ready = 1'b0;
        step();
        @(negedge ACLK);
        chk("prerst_valid", s2_valid, 1);
        chk("prerst_grant", gidx2, 1);
        ARESETn = 1'b0;
        step();
        ARESETn = 1'b1;
        m2_valid = 2'b11; s2_ready = 1'b1;
        q2.push_back(mk(0));
        @(negedge ACLK);
        chk("midrst_valid", s2_valid, 0);
        chk("midrst_push", push2, 0);
        chk("midrst_ready", m2_ready, 0);
        chk("midrst_grant", gidx2, 0);
        step();
        @(negedge ACLK);
        chk("postrst_first_grant", gidx2, 0);
        chk("postrst_valid", s2_valid, 1);
        step();
        m2_valid = 2'b00;

        // Three masters all requesting: wrap check
        m3_valid = 3'b111; s3_ready = 1'b1;
`ifdef XBAR_AR_ARB_FIXED_PRIO_EN
        for (int k = 0; k < 4; k++) q3.push_back(mk(0));
`else
        for (int k = 0; k < 4; k++) q3.push_back(mk(k % 3));
`endif
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            @(negedge ACLK);
            if (push3) cnt++;
        end
        m3_valid = 3'b000;
        chk("d3_push_count_8cyc", cnt, 4);

        repeat (2) step();
        chk("d2_queue_drained", q2.size(), 0);
        chk("d3_queue_drained", q3.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
